move_controller: RTL and testbench
==================================

// Module: move_controller
// PURPOSE
//  Turns raw mouse-button presses and the cursor square into the pick_piece / place_piece / figure_position
//  commands consumed by chess_board. Sits directly upstream of chess_board.
//  Enforces side-to-move, legality against possible_moves, cancel-by-dropping-on-origin, captures and king-capture game over.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synchronised samples required to accept a new button level
//  SETTLE_CYCLES    4   wait after pick before possible_moves is trusted (move-generator latency)
// PORTS
//  clk              in   1   system clock
//  rst              in   1   asynchronous, active-high reset
//  mouse_left       in   1   raw left button, asynchronous to clk
//  cursor_pos       in   6   square under cursor: [5:3] row, [2:0] column
//  piece_at_cursor  in   4   board code at cursor_pos: 0 empty, 1-6 white (6 king), 7-C black (C king)
//  possible_moves   in   64  legal targets of the held piece; square idx legal when bit [63-idx]=1
//  figure_position  out  6   square for pick/place, valid while a pulse is high
//  pick_piece       out  1   one-cycle pick command
//  place_piece      out  1   one-cycle place command
//  turn             out  1   side to move: 0 white, 1 black
//  piece_held       out  1   high from PICK until PLACE completes
//  capture_valid    out  1   one-cycle pulse with place_piece when the target held a piece
//  captured_code    out  4   code of last captured piece (holds value)
//  illegal_click    out  1   one-cycle pulse: rejected click while HELD
//  game_over        out  1   set when a king is captured; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, debounced level 0.
//  Input path: mouse_left -> 2-FF synchroniser -> debouncer.
//   Debounced level btn_db changes only after DEBOUNCE_CYCLES consecutive equal samples differing from it.
//   click = one-cycle pulse in the cycle after btn_db goes 0->1. Releases generate nothing.
//   cursor_pos, piece_at_cursor and possible_moves are sampled in the click cycle.
//  FSM:
//   IDLE:   on click, if piece_at_cursor belongs to turn (white 1-6 when turn=0, black 7-C when turn=1),
//           latch origin=cursor_pos and go to PICK. Other clicks are ignored silently.
//   PICK:   pick_piece=1 and figure_position=origin for exactly 1 cycle; piece_held<=1; go to SETTLE.
//   SETTLE: count SETTLE_CYCLES cycles, then go to HELD. Clicks during SETTLE are dropped.
//   HELD, on click:
//     - cursor_pos==origin: latch target=origin, cancel=1, go to PLACE.
//     - possible_moves[63-cursor_pos]==1: latch target, cancel=0, latch victim=piece_at_cursor, go to PLACE.
//     - otherwise: illegal_click pulse 1 cycle, stay in HELD.
//   PLACE:  place_piece=1 and figure_position=target for 1 cycle; piece_held<=0.
//     - If cancel=0: toggle turn.
//     - If cancel=0 and victim!=0: capture_valid=1 and captured_code<=victim.
//     - If victim is 6 or C: go to OVER; otherwise go to IDLE.
//   OVER:   all clicks ignored, no pulses; game_over=1 until rst.
//  figure_position holds its last value outside pulses. All outputs are registered; no combinational in->out paths.
//  Latency: click -> pick_piece is 1 cycle; HELD click -> place_piece is 1 cycle.
//  pick_piece and place_piece are never high together. At most one command per click.
//  Clicks are never queued; a click arriving in PICK, SETTLE or PLACE is lost.
//  Reset mid-operation (any state): immediate return to reset values. chess_board shares rst, so no piece is lost.
//  Debounce and settle counters are sized with $clog2(param+1); no wrap-around can occur.
// TESTING
//  1 Reset, hold mouse_left high for DEBOUNCE_CYCLES+3 cycles on cursor 6'o64 (code 1)
//    -> single pick_piece with figure_position=6'o64; piece_held=1.
//  2 Continue 1: click 6'o44 with bit 63-36 set
//    -> place_piece, figure_position=6'o44, turn=1, capture_valid=0.
//  3 Bounce: toggle mouse_left every 3 cycles for 40 cycles, DEBOUNCE_CYCLES=16
//    -> no click, no pulses, state IDLE.
//  4 turn=0, click a black pawn (7), then an empty square -> no outputs.
//    Pick a white pawn; click an illegal square -> illegal_click only.
//    Click the origin -> place at origin, turn stays 0.
//  5 Held move onto code C with its bit set -> capture_valid=1, captured_code=C, game_over=1;
//    further clicks produce no pulses.
//  6 Assert rst while in SETTLE -> next cycle all outputs 0, turn=0;
//    a fresh legal pick is accepted after release.

Source files
------------

// File: rtl/move_controller.sv
// Purpose : turns debounced mouse clicks and the cursor square into pick/place commands for chess_board,
//           enforcing side-to-move, legality against possible_moves, cancel-on-origin, captures and game over.
// Latency : click -> pick_piece 1 cycle; HELD click -> place_piece / illegal_click 1 cycle; all outputs registered.
// Backpressure: none; clicks that arrive outside IDLE/HELD are dropped, never queued.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   mouse_left        raw button, asynchronous to clk (synchronised + debounced here)
//   cursor_pos        square under cursor, [5:3] row, [2:0] column
//   piece_at_cursor   board code at cursor: 0 empty, 1-6 white (6 king), 7-12 black (12 king)
//   possible_moves    legal targets of the held piece, square idx legal when bit [63-idx] is set
//   figure_position   square for the current pick/place pulse, holds its value otherwise
//   pick_piece        one-cycle pick command
//   place_piece       one-cycle place command
//   turn              side to move, 0 white / 1 black
//   piece_held        high from pick until the place completes
//   capture_valid     one-cycle pulse alongside place_piece when the target held a piece
//   captured_code     code of the last captured piece
//   illegal_click     one-cycle pulse on a rejected click while a piece is held
//   game_over         sticky once a king is captured, cleared only by rst
module move_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [5:0]  cursor_pos,
  input  logic [3:0]  piece_at_cursor,
  input  logic [63:0] possible_moves,
  output logic [5:0]  figure_position,
  output logic        pick_piece,
  output logic        place_piece,
  output logic        turn,
  output logic        piece_held,
  output logic        capture_valid,
  output logic [3:0]  captured_code,
  output logic        illegal_click,
  output logic        game_over
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_SETTLE, S_HELD, S_PLACE, S_OVER
  } state_t;

  // Input path state
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           btn_db_q, btn_db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           click_q, click_d;

  // Move FSM state and registered outputs
  state_t         state_q, state_d;
  logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [5:0]     origin_q, origin_d;
  logic [3:0]     victim_q, victim_d;
  logic           cancel_q, cancel_d;
  logic [5:0]     fig_q, fig_d;
  logic           pick_q, pick_d;
  logic           place_q, place_d;
  logic           turn_q, turn_d;
  logic           held_q, held_d;
  logic           cap_vld_q, cap_vld_d;
  logic [3:0]     cap_code_q, cap_code_d;
  logic           illegal_q, illegal_d;
  logic           over_q, over_d;

  logic           own_piece;
  logic           target_legal;

  // Synchroniser and debouncer. The counter only runs while the synchronised
  // sample disagrees with the accepted level; any agreeing sample restarts it.
  always_comb begin
    sync1_d  = mouse_left;
    sync2_d  = sync1_q;
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    click_d  = 1'b0;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = sync2_q;
        click_d  = sync2_q;  // only the 0->1 acceptance is a click
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    if (turn_q) own_piece = (piece_at_cursor >= 4'd7) && (piece_at_cursor <= 4'd12);
    else        own_piece = (piece_at_cursor >= 4'd1) && (piece_at_cursor <= 4'd6);
  end

  assign target_legal = possible_moves[6'd63 - cursor_pos];

  // Pulse outputs are loaded on the edge entering PICK/PLACE so they are high
  // during that state; turn, piece_held release and game_over update on exit of PLACE.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    origin_d     = origin_q;
    victim_d     = victim_q;
    cancel_d     = cancel_q;
    fig_d        = fig_q;
    pick_d       = 1'b0;
    place_d      = 1'b0;
    turn_d       = turn_q;
    held_d       = held_q;
    cap_vld_d    = 1'b0;
    cap_code_d   = cap_code_q;
    illegal_d    = 1'b0;
    over_d       = over_q;

    case (state_q)
      S_IDLE: begin
        if (click_q && own_piece) begin
          origin_d = cursor_pos;
          fig_d    = cursor_pos;
          pick_d   = 1'b1;
          held_d   = 1'b1;
          state_d  = S_PICK;
        end
      end
      S_PICK: begin
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = S_HELD;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        if (click_q) begin
          if (cursor_pos == origin_q) begin
            // Dropping back on the origin cancels: no turn change, no capture.
            fig_d    = origin_q;
            cancel_d = 1'b1;
            victim_d = 4'd0;
            place_d  = 1'b1;
            state_d  = S_PLACE;
          end else if (target_legal) begin
            fig_d    = cursor_pos;
            cancel_d = 1'b0;
            victim_d = piece_at_cursor;
            place_d  = 1'b1;
            if (piece_at_cursor != 4'd0) begin
              cap_vld_d  = 1'b1;
              cap_code_d = piece_at_cursor;
            end
            state_d  = S_PLACE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_PLACE: begin
        held_d = 1'b0;
        if (!cancel_q) turn_d = ~turn_q;
        if ((victim_q == 4'd6) || (victim_q == 4'd12)) begin
          over_d  = 1'b1;
          state_d = S_OVER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      click_q      <= 1'b0;
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      origin_q     <= 6'd0;
      victim_q     <= 4'd0;
      cancel_q     <= 1'b0;
      fig_q        <= 6'd0;
      pick_q       <= 1'b0;
      place_q      <= 1'b0;
      turn_q       <= 1'b0;
      held_q       <= 1'b0;
      cap_vld_q    <= 1'b0;
      cap_code_q   <= 4'd0;
      illegal_q    <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_db_q     <= btn_db_d;
      db_cnt_q     <= db_cnt_d;
      click_q      <= click_d;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      origin_q     <= origin_d;
      victim_q     <= victim_d;
      cancel_q     <= cancel_d;
      fig_q        <= fig_d;
      pick_q       <= pick_d;
      place_q      <= place_d;
      turn_q       <= turn_d;
      held_q       <= held_d;
      cap_vld_q    <= cap_vld_d;
      cap_code_q   <= cap_code_d;
      illegal_q    <= illegal_d;
      over_q       <= over_d;
    end
  end

  assign figure_position = fig_q;
  assign pick_piece      = pick_q;
  assign place_piece     = place_q;
  assign turn            = turn_q;
  assign piece_held      = held_q;
  assign capture_valid   = cap_vld_q;
  assign captured_code   = cap_code_q;
  assign illegal_click   = illegal_q;
  assign game_over       = over_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: a table of hand-derived click vectors, hand sequences
// for bounce rejection and reset during settle, then random clicks against a
// click-level reference model of the game rules.
`timescale 1ns/1ps
module tb_move_controller;

  localparam int DEB = 16;
  localparam int SET = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mouse_left = 1'b0;
  logic [5:0]  cursor_pos = 6'd0;
  logic [3:0]  piece_at_cursor = 4'd0;
  logic [63:0] possible_moves = 64'd0;
  logic [5:0]  figure_position;
  logic        pick_piece, place_piece, turn, piece_held;
  logic        capture_valid, illegal_click, game_over;
  logic [3:0]  captured_code;

  always #5 clk = ~clk;

  move_controller #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .cursor_pos(cursor_pos),
    .piece_at_cursor(piece_at_cursor), .possible_moves(possible_moves),
    .figure_position(figure_position), .pick_piece(pick_piece), .place_piece(place_piece),
    .turn(turn), .piece_held(piece_held), .capture_valid(capture_valid),
    .captured_code(captured_code), .illegal_click(illegal_click), .game_over(game_over)
  );

  typedef enum int {K_NONE, K_PICK, K_PLACE, K_ILL} kind_e;

  typedef struct {
    logic [5:0]  cur;
    logic [3:0]  pc;
    logic [63:0] mv;
    kind_e       k;
    logic [5:0]  fig;
    logic        trn;
    logic        held;
    logic        cap;
    logic [3:0]  code;
    logic        over;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Pulse observations gathered over one click window
  int n_pick, n_place, n_ill, n_cap, n_bad;

  // Reference model state (click level)
  logic       m_turn, m_hold, m_over;
  logic [5:0] m_origin, m_fig;
  logic [3:0] m_code;

  function automatic logic [63:0] sq(input int idx);
    logic [63:0] one;
    one = 64'd1;
    return one << (63 - idx);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fig"},   64'(figure_position), 64'd0);
    chk({tag, " pick"},  64'(pick_piece), 64'd0);
    chk({tag, " place"}, 64'(place_piece), 64'd0);
    chk({tag, " turn"},  64'(turn), 64'd0);
    chk({tag, " held"},  64'(piece_held), 64'd0);
    chk({tag, " cap"},   64'(capture_valid), 64'd0);
    chk({tag, " code"},  64'(captured_code), 64'd0);
    chk({tag, " ill"},   64'(illegal_click), 64'd0);
    chk({tag, " over"},  64'(game_over), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero(tag);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sample_pulses();
    if (pick_piece)    n_pick++;
    if (place_piece)   n_place++;
    if (illegal_click) n_ill++;
    if (capture_valid) n_cap++;
    if (pick_piece && place_piece)    n_bad++;
    if (capture_valid && !place_piece) n_bad++;
  endtask

  task automatic clear_obs();
    n_pick = 0; n_place = 0; n_ill = 0; n_cap = 0; n_bad = 0;
  endtask

  // One clean press (20 cycles) and release (24 cycles), inputs held steady.
  task automatic press(input logic [5:0] cur, input logic [3:0] pc, input logic [63:0] mv);
    cursor_pos = cur;
    piece_at_cursor = pc;
    possible_moves = mv;
    clear_obs();
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      sample_pulses();
      mouse_left = (i < 20);
    end
    mouse_left = 1'b0;
  endtask

  task automatic check_obs(input string tag, input kind_e k, input logic [5:0] fig, input logic trn,
                           input logic held, input logic cap, input logic [3:0] code, input logic over);
    chk({tag, " pick_cnt"},  64'(n_pick),  (k == K_PICK)  ? 64'd1 : 64'd0);
    chk({tag, " place_cnt"}, 64'(n_place), (k == K_PLACE) ? 64'd1 : 64'd0);
    chk({tag, " ill_cnt"},   64'(n_ill),   (k == K_ILL)   ? 64'd1 : 64'd0);
    chk({tag, " cap_cnt"},   64'(n_cap),   cap ? 64'd1 : 64'd0);
    chk({tag, " overlap"},   64'(n_bad),   64'd0);
    chk({tag, " fig"},       64'(figure_position), 64'(fig));
    chk({tag, " turn"},      64'(turn),    64'(trn));
    chk({tag, " held"},      64'(piece_held), 64'(held));
    chk({tag, " code"},      64'(captured_code), 64'(code));
    chk({tag, " over"},      64'(game_over), 64'(over));
  endtask

  task automatic model_reset();
    m_turn = 1'b0; m_hold = 1'b0; m_over = 1'b0;
    m_origin = 6'd0; m_fig = 6'd0; m_code = 4'd0;
  endtask

  // Game rules at click granularity: what one isolated click should produce.
  task automatic model_click(input logic [5:0] cur, input logic [3:0] pc, input logic [63:0] mv,
                             output kind_e k, output logic cap);
    int  idx;
    bit  mine;
    k = K_NONE;
    cap = 1'b0;
    idx = 63 - int'(cur);
    mine = (m_turn == 1'b0) ? (pc inside {[4'd1:4'd6]}) : (pc inside {[4'd7:4'd12]});
    if (m_over) begin
      k = K_NONE;
    end else if (!m_hold) begin
      if (mine) begin
        k = K_PICK; m_hold = 1'b1; m_origin = cur; m_fig = cur;
      end
    end else if (cur == m_origin) begin
      k = K_PLACE; m_hold = 1'b0; m_fig = cur;
    end else if (mv[idx]) begin
      k = K_PLACE; m_hold = 1'b0; m_fig = cur; m_turn = ~m_turn;
      if (pc != 4'd0) begin cap = 1'b1; m_code = pc; end
      if (pc == 4'd6 || pc == 4'd12) m_over = 1'b1;
    end else begin
      k = K_ILL;
    end
  endtask

  vec_t tbl[12];

  initial begin
    kind_e      k;
    logic       cap;
    logic [5:0] cur;
    logic [3:0] pc;
    logic [63:0] mv;
    bit         found;
    int         r;

    tbl[0]  = '{6'o64, 4'd1,  64'd0,       K_PICK,  6'o64, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    tbl[1]  = '{6'o44, 4'd0,  sq(6'o44),   K_PLACE, 6'o44, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[2]  = '{6'o14, 4'd7,  64'd0,       K_PICK,  6'o14, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0};
    tbl[3]  = '{6'o24, 4'd0,  sq(6'o24),   K_PLACE, 6'o24, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[4]  = '{6'o13, 4'd7,  64'd0,       K_NONE,  6'o24, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[5]  = '{6'o33, 4'd0,  64'd0,       K_NONE,  6'o24, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[6]  = '{6'o63, 4'd1,  64'd0,       K_PICK,  6'o63, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    tbl[7]  = '{6'o40, 4'd0,  sq(6'o43),   K_ILL,   6'o63, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    tbl[8]  = '{6'o63, 4'd1,  64'd0,       K_PLACE, 6'o63, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[9]  = '{6'o73, 4'd5,  64'd0,       K_PICK,  6'o73, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    tbl[10] = '{6'o03, 4'd12, sq(6'o03),   K_PLACE, 6'o03, 1'b1, 1'b0, 1'b1, 4'd12, 1'b1};
    tbl[11] = '{6'o14, 4'd7,  64'd0,       K_NONE,  6'o03, 1'b1, 1'b0, 1'b0, 4'd12, 1'b1};

    // Reset values, then the table of isolated clicks
    do_reset("reset0");
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].cur, tbl[i].pc, tbl[i].mv);
      check_obs($sformatf("tbl%0d", i), tbl[i].k, tbl[i].fig, tbl[i].trn,
                tbl[i].held, tbl[i].cap, tbl[i].code, tbl[i].over);
    end

    // Bouncing button: level never stable long enough to register
    do_reset("reset1");
    cursor_pos = 6'o64; piece_at_cursor = 4'd1; possible_moves = 64'd0;
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sample_pulses();
      mouse_left = (((i / 3) % 2) == 0);
    end
    mouse_left = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      sample_pulses();
    end
    check_obs("bounce", K_NONE, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    press(6'o64, 4'd1, 64'd0);
    check_obs("bounce_then_pick", K_PICK, 6'o64, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // Reset while in SETTLE after a black pick
    do_reset("reset2");
    press(6'o64, 4'd1, 64'd0);
    press(6'o44, 4'd0, sq(6'o44));
    check_obs("t6_setup", K_PLACE, 6'o44, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cursor_pos = 6'o14; piece_at_cursor = 4'd7; possible_moves = 64'd0;
    found = 1'b0;
    mouse_left = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pick_piece) found = 1'b1;
    end
    chk("t6 pick seen", 64'(found), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("t6 rst_in_settle");
    mouse_left = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);
    press(6'o64, 4'd1, 64'd0);
    check_obs("t6_after", K_PICK, 6'o64, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // Random clicks against the rule model
    do_reset("reset3");
    model_reset();
    for (int n = 0; n < 60; n++) begin
      if (m_over) begin
        do_reset($sformatf("rnd%0d reset", n));
        model_reset();
      end
      mv = {$urandom, $urandom};
      cur = 6'($urandom_range(0, 63));
      if (!m_hold) begin
        r = $urandom_range(0, 3);
        if (r == 0)      pc = 4'($urandom_range(0, 15));
        else if (m_turn) pc = 4'($urandom_range(7, 12));
        else             pc = 4'($urandom_range(1, 6));
      end else begin
        r = $urandom_range(0, 9);
        if (r < 2)      cur = m_origin;
        else if (r < 6) mv = mv | sq(int'(cur));
        pc = 4'($urandom_range(0, 12));
        if ((pc == 4'd6 || pc == 4'd12) && $urandom_range(0, 3) != 0) pc = 4'd0;
      end
      model_click(cur, pc, mv, k, cap);
      press(cur, pc, mv);
      check_obs($sformatf("rnd%0d", n), k, m_fig, m_turn, m_hold, cap, m_code, m_over);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
